// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES-128 widths, round-key FSM states and GF(2^8) helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int KEY_W   = 128;
  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rk_state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module : aes_sbox
// Brief  : Combinational AES forward S-box, one byte in and one byte out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry for input value i sits at bits [8*(255-i) +: 8].
  localparam logic [2047:0] c_sbox_table = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;

  assign w_base = {~byte_i, 3'b000};
  assign byte_o = c_sbox_table[w_base +: 8];

endmodule

`default_nettype wire

// File: rtl/round_key_gen.sv
// ============================================================================
// Module : round_key_gen
// Brief  : On-the-fly AES-128 key expansion, one round key per cycle on request.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_key_gen
  import aes_pkg::*;
#(
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             start,
  input  logic             next,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_idx,
  output logic             rk_valid,
  output logic             last
);

  if (Nr != 10 || KEY_W != BLOCK_W) begin : g_nr_check
    $error("round_key_gen: only AES-128 with Nr = 10 is supported");
  end

  localparam logic [3:0] c_last_idx = 4'(Nr);

  rk_state_e        state_q;
  logic [KEY_W-1:0] rk_q;
  logic [KEY_W-1:0] rk_d;
  logic [3:0]       idx_q;
  logic [7:0]       rcon_q;
  logic             valid_q;
  logic             last_q;

  logic [WORD_W-1:0] w_rot;
  logic [WORD_W-1:0] w_sub;
  logic [WORD_W-1:0] w_t;
  logic [WORD_W-1:0] w_n0;
  logic [WORD_W-1:0] w_n1;
  logic [WORD_W-1:0] w_n2;
  logic [WORD_W-1:0] w_n3;

  assign w_rot = rot_word(rk_q[WORD_W-1:0]);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (w_rot[8*g +: 8]),
      .byte_o (w_sub[8*g +: 8])
    );
  end

  // Each new word chains off the freshly computed previous word.
  assign w_t  = w_sub ^ {rcon_q, 24'h000000};
  assign w_n0 = rk_q[127:96] ^ w_t;
  assign w_n1 = rk_q[95:64]  ^ w_n0;
  assign w_n2 = rk_q[63:32]  ^ w_n1;
  assign w_n3 = rk_q[31:0]   ^ w_n2;
  assign rk_d = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (start) begin
      state_q <= ST_ACTIVE;
      rk_q    <= key_in;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
      valid_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (next) begin
            if (idx_q < c_last_idx) begin
              rk_q   <= rk_d;
              idx_q  <= idx_q + 4'd1;
              rcon_q <= xtime(rcon_q);
              last_q <= (idx_q == c_last_idx - 4'd1);
            end else begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end
          end
        end
        ST_IDLE: begin
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rk_out   = rk_q;
  assign rk_idx   = idx_q;
  assign rk_valid = valid_q;
  assign last     = last_q;

endmodule

`default_nettype wire

// File: tb/tb_round_key_gen.sv
// ============================================================================
// Module : tb_round_key_gen
// Brief  : Self-checking bench for round_key_gen against an AES key-schedule model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_key_gen;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         start;
  logic         next;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         last;

  int n_checks = 0;
  int n_errors = 0;

  round_key_gen #(.Nr(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .start    (start),
    .next     (next),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .last     (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   ref_sbox [256];
  logic [127:0] m_keys   [11];
  logic [127:0] m_out;
  logic [3:0]   m_idx;
  logic         m_active;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] aa = a;
    logic [7:0] p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    int rc;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {ref_sbox[tmp[31:24]], ref_sbox[tmp[23:16]],
               ref_sbox[tmp[15:8]],  ref_sbox[tmp[7:0]]};
        tmp = tmp ^ {8'(rc), 24'h0};
        rc = rc << 1;
        if ((rc & 'h100) != 0) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance model and DUT by one clock, then compare every output.
  task automatic step();
    if (!rst_n) begin
      m_active = 1'b0; m_out = '0; m_idx = 4'd0;
    end else if (start) begin
      build_schedule(key_in);
      m_active = 1'b1; m_idx = 4'd0; m_out = m_keys[0];
    end else if (m_active && next) begin
      if (m_idx < 4'd10) begin
        m_idx = m_idx + 4'd1;
        m_out = m_keys[m_idx];
      end else begin
        m_active = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("rk_valid", 128'(rk_valid), 128'(m_active));
    chk("rk_idx",   128'(rk_idx),   128'(m_idx));
    chk("rk_out",   rk_out,         m_out);
    chk("last",     128'(last),     128'(m_active && m_idx == 4'd10));
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    int           idx;
    logic [127:0] rk;
    logic         last_exp;
  } kat_t;

  kat_t kat [4];
  localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] seen [11];
  int           n_seen;

  initial begin
    kat[0] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
    kat[1] = '{1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
    kat[2] = '{2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
    kat[3] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};

    m_active = 1'b0; m_out = '0; m_idx = 4'd0;
    rst_n = 1'b0; start = 1'b0; next = 1'b0; key_in = '0;
    build_sbox();

    // reset for two cycles
    step(); step();
    chk("reset_valid", 128'(rk_valid), 128'd0);
    chk("reset_out",   rk_out,         128'd0);
    chk("reset_idx",   128'(rk_idx),   128'd0);
    rst_n = 1'b1;
    next = 1'b1; step(); next = 1'b0;   // next ignored before any start

    // next held high from index 0
    key_in = c_fips_key; start = 1'b1; step();
    start = 1'b0; next = 1'b1; key_in = 128'hdeadbeef;
    for (int i = 0; i <= 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (kat[j].idx == i) begin
          chk($sformatf("held_rk%0d", i),   rk_out,         kat[j].rk);
          chk($sformatf("held_last%0d", i), 128'(last),     128'(kat[j].last_exp));
        end
      end
      step();
    end
    chk("held_done_valid", 128'(rk_valid), 128'd0);
    next = 1'b0;

    // sparse next pulses, same key
    key_in = c_fips_key; start = 1'b1; step(); start = 1'b0;
    n_seen = 0;
    seen[0] = rk_out; n_seen = 1;
    while (m_active) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        key_in = {$urandom, $urandom, $urandom, $urandom};
        step();
      end
      next = 1'b1; step(); next = 1'b0;
      if (m_active && n_seen < 11) begin seen[n_seen] = rk_out; n_seen++; end
    end
    chk("sparse_count", 128'(n_seen), 128'd11);
    for (int j = 0; j < 4; j++) chk($sformatf("sparse_rk%0d", kat[j].idx), seen[kat[j].idx], kat[j].rk);

    // next pulses while idle after completing the schedule
    for (int p = 0; p < 4; p++) begin
      next = 1'b1; step(); next = 1'b0; step();
    end
    chk("idle_hold_rk", rk_out, kat[3].rk);
    chk("idle_hold_idx", 128'(rk_idx), 128'd10);

    // start and next together at index 5
    key_in = c_fips_key; start = 1'b1; step(); start = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 5; i++) step();
    start = 1'b1; step(); start = 1'b0;
    chk("restart_idx", 128'(rk_idx), 128'd0);
    chk("restart_rk",  rk_out,       kat[0].rk);
    step();
    chk("restart_rk1", rk_out,       kat[1].rk);
    next = 1'b0;

    // reset at index 4, then next ignored
    key_in = c_fips_key; start = 1'b1; step(); start = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("midreset_out", rk_out, 128'd0);
    chk("midreset_valid", 128'(rk_valid), 128'd0);
    next = 1'b0;

    // randomized traffic with random keys
    for (int c = 0; c < 1500; c++) begin
      rst_n  = ($urandom_range(0, 63) != 0);
      start  = ($urandom_range(0, 15) == 0);
      next   = $urandom_range(0, 1) == 1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_key_gen.md
ROUND_KEY_GEN -- requirements
Module: round_key_gen

Interface
REQ-001 Parameter: Nr, 10, number of AES-128 rounds; only 10 is supported, and any other value is a synthesis-time error.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: key_in  input  128  cipher key; bits [127:96] are word w0.
REQ-005 Port: start  input  1  single-cycle request to load key_in and restart the schedule.
REQ-006 Port: next  input  1  request to advance to the following round key.
REQ-007 Port: rk_out  output  128  current round key, registered.
REQ-008 Port: rk_idx  output  4  round number (0..Nr) of rk_out.
REQ-009 Port: rk_valid  output  1  high while rk_out holds a valid round key.
REQ-010 Port: last  output  1  high when rk_valid=1 and rk_idx=Nr.

Function
REQ-011 FSM states: IDLE, ACTIVE; state after reset is IDLE.
REQ-012 IDLE behaviour: rk_valid=0; next is ignored; rk_out and rk_idx hold their values.
REQ-013 start=1 in any state: on the next edge, rk_out=key_in, rk_idx=0, rcon=8'h01, rk_valid=1, state=ACTIVE; latency 1 cycle.
REQ-014 start takes priority over next in the same cycle.
REQ-015 ACTIVE, next=1, rk_idx<Nr: on the next edge, rk_out=expand(rk_out, rcon), rk_idx+1, and rcon=xtime(rcon); one round key per cycle.
REQ-016 expand definition: t = SubWord(RotWord(w3)) XOR {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-017 RotWord definition: {b1,b2,b3,b0}.
REQ-018 SubWord definition: AES S-box applied to each of the 4 bytes.
REQ-019 xtime definition: left shift by one bit, XOR 8'h1b if the shifted-out MSB was 1; rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
REQ-020 ACTIVE, next=1, rk_idx=Nr: on the next edge, state=IDLE and rk_valid=0; rk_out and rk_idx hold.
REQ-021 ACTIVE, next=0: all outputs hold; no timeout.
REQ-022 next held high continuously from index 0 produces indices 0..10 on consecutive cycles, then drops rk_valid.
REQ-023 key_in is sampled only on a start cycle; key_in changes at any other time have no effect.
REQ-024 rk_out is a register output with no combinational path from any input.

Reset
REQ-025 rst_n=0 at a clock edge: state=IDLE, rk_out=0, rk_idx=0, rk_valid=0, last=0, rcon=8'h01.
REQ-026 Reset has priority over start and next, including when asserted mid-schedule.
REQ-027 The first start after reset release behaves per REQ-013.

Structure
REQ-028 Shared package aes_pkg holds: state enum, RCON_INIT=8'h01, RCON_POLY=8'h1b, and the key/block width constants (128 bits).
REQ-029 S-box is a separate combinational sub-module, aes_sbox (8-bit in, 8-bit out), instantiated 4 times; it is shared with the cipher datapath.
REQ-030 Exactly one 128-bit round-key register is used; no storage of the full expanded schedule.

Verification
REQ-031 Scenario: rst_n=0 for 2 cycles -> rk_valid=0, rk_out=0, rk_idx=0.
REQ-032 Scenario: start with key 2b7e151628aed2a6abf7158809cf4f3c, next held high -> idx0=2b7e1516..., idx1=a0fafe1788542cb123a339392a6c7605, idx2=f2c295f27a96b9435935807a7359f67f, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6 with last=1, rk_valid=0 on the following cycle.
REQ-033 Scenario: next pulsed sparsely (gaps of 0-3 cycles) with the same key -> identical 11-key sequence; outputs stable during gaps.
REQ-034 Scenario: start and next both high at idx 5 -> next cycle idx=0, rk_out=key_in, rcon restarted (idx1 matches REQ-032).
REQ-035 Scenario: rst_n=0 at idx 4 -> IDLE, all outputs 0; next then ignored until a new start.
REQ-036 Scenario: next pulses while IDLE -> no change to rk_out, rk_idx or rk_valid.
